// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter: framebuffer geometry,
// display timing limits, the RGB444 pixel type and the queued write entry.
package vga_fb_arbiter_pkg;

  localparam int FB_W          = 160;
  localparam int FB_H          = 120;
  localparam int FB_WORDS      = 19200;
  localparam int SCALE_SHIFT   = 2;
  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;

  localparam int POS_W         = 10;
  localparam int ADDR_W        = 15;
  localparam int PIX_W         = 12;
  localparam int WR_FIFO_DEPTH = 2;

  typedef logic [PIX_W-1:0]  rgb444;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    rgb444    data;
  } wr_entry_t;

  localparam int WR_ENTRY_W = $bits(wr_entry_t);

  // row*160 + col without a multiplier: 160 = 128 + 32.
  function automatic fb_addr_t fb_word_addr(input logic [POS_W-SCALE_SHIFT-1:0] row,
                                            input logic [POS_W-SCALE_SHIFT-1:0] col);
    fb_addr_t r;
    r = fb_addr_t'(row);
    return (r << 7) + (r << 5) + fb_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// Small synchronous FIFO holding pending framebuffer writes; head is visible
// combinationally and popped by the arbiter whenever the RAM port is free.
module fb_wr_fifo #(
  parameter int depth = 2,
  parameter int width = 27
) (
  input  logic                         clk_25MHz,
  input  logic                         rst_,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  input  logic                         pop,
  output logic [width-1:0]             head,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(depth);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(depth - 1);

  logic [width-1:0] store [depth];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != FULL);
  assign head    = store[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: storage is deliberately left out of reset; count alone says which
  // entries are valid, so clearing the array would only cost flops and routing.
  always_ff @(posedge clk_25MHz) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_25MHz or negedge rst_) begin
    if (!rst_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one framebuffer RAM port between the 4x-scaled display fetch and a
// buffered writer; display fetches always win, writes drain on free cycles.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input  logic              clk_25MHz,
  input  logic              rst_,
  input  logic [9:0]        h_pos,
  input  logic [9:0]        v_pos,
  input  logic              wr_valid,
  input  logic [14:0]       wr_addr,
  input  logic [11:0]       wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic [14:0]       mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       rgb_out,
  output logic              vblank
);

  localparam int CNT_W = $clog2(WR_FIFO_DEPTH + 1);
  localparam int IDX_W = POS_W - SCALE_SHIFT;

  logic [POS_W-1:0] h_ahead;
  logic [IDX_W-1:0] fetch_row;
  logic [IDX_W-1:0] fetch_col;
  fb_addr_t         fetch_addr;
  logic             fetch_slot;
  logic             in_range;
  logic             accept;
  logic             push;
  logic             pop;
  wr_entry_t        push_entry;
  wr_entry_t        head;
  logic [CNT_W-1:0] fifo_count;
  fb_addr_t         last_addr_q;
  rgb444            last_wdata_q;
  logic             fetch_d;

  // Fetch two pixels ahead so the RAM read latency plus the output register
  // lands word c exactly on screen columns 4c..4c+3.
  assign h_ahead    = h_pos + POS_W'(2);
  assign fetch_row  = v_pos[POS_W-1:SCALE_SHIFT];
  assign fetch_col  = h_ahead[POS_W-1:SCALE_SHIFT];
  assign fetch_addr = fb_word_addr(fetch_row, fetch_col);

  // Gating with rst_ keeps mem_addr at 0 while reset is held.
  assign fetch_slot = rst_
                   && (h_pos[1:0] == 2'b10)
                   && (h_ahead < POS_W'(H_ACTIVE))
                   && (v_pos < POS_W'(V_ACTIVE));

  assign vblank     = (v_pos >= POS_W'(V_ACTIVE));

  assign wr_ready   = (fifo_count < CNT_W'(WR_FIFO_DEPTH));
  assign in_range   = (wr_addr < ADDR_W'(FB_WORDS));
  assign accept     = wr_valid && wr_ready;
  assign push       = accept && in_range;
  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign pop        = !fetch_slot && (fifo_count != '0);

  fb_wr_fifo #(
    .depth (WR_FIFO_DEPTH),
    .width (WR_ENTRY_W)
  ) u_wr_fifo (
    .clk_25MHz (clk_25MHz),
    .rst_      (rst_),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // NOTE: every output gets a default first so no path through the block
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    mem_we    = 1'b0;
    if (fetch_slot) begin
      mem_addr = fetch_addr;
    end else if (pop) begin
      mem_addr  = head.addr;
      mem_wdata = head.data;
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_) begin
    if (!rst_) begin
      wr_err       <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      fetch_d      <= 1'b0;
      rgb_out      <= '0;
    end else begin
      if (accept && !in_range) wr_err <= 1'b1;
      last_addr_q  <= mem_addr;
      last_wdata_q <= mem_wdata;
      fetch_d      <= fetch_slot;
      if (fetch_d) rgb_out <= mem_rdata;
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-low. Ports:
- clk_25MHz  in  1  pixel clock; all state changes on its rising edge.
- rst_  in  1  asynchronous active-low reset.
- h_pos  in  10  display column; value < 640 is active, otherwise blanking; wraps modulo 1024.
- v_pos  in  10  display row; value < 480 is active.
- wr_valid  in  1  writer request.
- wr_addr  in  15  framebuffer word address (row*160+col).
- wr_data  in  12  RGB444 pixel.
- wr_ready  out  1  write accept.
- wr_err  out  1  sticky flag: an out-of-range write was dropped.
- mem_addr  out  15  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  12  RAM write data.
- mem_rdata  in  12  RAM read data, valid 1 cycle after mem_addr.
- rgb_out  out  12  pixel to the display datapath.
- vblank  out  1  high when v_pos >= 480.

Function
REQ-002 The framebuffer SHALL be 160x120 words of 12 bits, and each word SHALL be displayed as a 4x4 block of screen pixels.
REQ-003 A fetch slot SHALL be any cycle with h_pos[1:0]==2'b10, ((h_pos+2) mod 1024) < 640 and v_pos < 480.
- Fetch column c = ((h_pos+2) mod 1024)>>2.
- Fetch row r = v_pos>>2.
- mem_addr = r*160 + c, computed with shifts and adds: (r<<7)+(r<<5)+c.
- mem_we = 0.
REQ-004 On the cycle after a fetch slot, mem_rdata SHALL be registered into rgb_out, so that column c is presented while h_pos is in 4c..4c+3.
- Column 0 is fetched at h_pos = 1022.
- No fetch occurs at h_pos = 638.
REQ-005 rgb_out SHALL hold its value between fetches and SHALL change only on the cycle after a fetch slot.
REQ-006 Writes SHALL pass through a 2-entry FIFO.
- wr_ready = (count < 2).
- A push occurs when wr_valid && wr_ready.
- There is no same-cycle bypass: minimum latency from accept to mem_we is 1 cycle.
REQ-007 A pushed entry with wr_addr >= 19200 SHALL be discarded and SHALL set wr_err; wr_err remains set until reset.
REQ-008 On any cycle that is not a fetch slot and has count > 0, the FIFO head SHALL drive mem_addr/mem_wdata with mem_we=1, and the head SHALL be popped.
REQ-009 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-010 A fetch slot SHALL always win over a pending write; the pending write is retried on the next non-fetch cycle.
REQ-011 Sustained write bandwidth SHALL be at least 3 words per 4 cycles during active lines and 1 word per cycle in blanking.
REQ-012 With no fetch and no pending write, mem_we SHALL be 0 and mem_addr SHALL hold its last value.
REQ-013 vblank SHALL be combinational from v_pos.

Reset
REQ-014 While rst_=0, the block SHALL drive:
- FIFO count = 0, wr_ready = 1, wr_err = 0;
- mem_we = 0, mem_addr = 0, mem_wdata = 0;
- rgb_out = 12'h000.
REQ-015 Reset asserted mid-operation SHALL discard FIFO contents, and no write SHALL reach the RAM after reset asserts.
REQ-016 After rst_ deasserts, the first fetch SHALL occur at the first qualifying h_pos; no warm-up frame is required.

Structure
REQ-017 A shared package SHALL hold the constants FB_W=160, FB_H=120, FB_WORDS=19200, SCALE_SHIFT=2, H_ACTIVE=640, V_ACTIVE=480, and the pixel type rgb444 (12 bits).
REQ-018 The 2-entry write FIFO SHALL be a sub-module named fb_wr_fifo (parameter depth=2, width=27); arbitration and fetch addressing stay in the top module.

Verification
REQ-019 Fetch addressing: preload RAM word 161 = 12'hABC, sweep h_pos/v_pos -> mem_addr=161 at h_pos=2, v_pos=4; rgb_out=12'hABC for h_pos 4..7.
REQ-020 Line start: v_pos=0, h_pos=1022 -> mem_addr=0 with mem_we=0; rgb_out = word 0 when h_pos=0.
REQ-021 Write collision: wr_valid held with addr 5, data 12'h123, during active video -> no mem_we on any fetch-slot cycle; word 5 = 12'h123 within 3 cycles of accept.
REQ-022 Backpressure: 4 back-to-back writes in the cycle before a fetch slot -> wr_ready drops to 0 after 2 accepts, and all 4 words are written in order.
REQ-023 Range check: write to addr 19200 -> no mem_we for it, wr_err=1 from the next cycle and held until rst_=0.
REQ-024 Reset mid-write: assert rst_=0 with 2 entries pending -> mem_we=0 immediately, wr_ready=1, and the RAM is unchanged.
